// File: rtl/dcpu_intctl_if.sv
// CPU-side register bus of the interrupt controller: address, write data, direction, read data.
// No handshake is carried: every access completes in the cycle it is presented.
// The bus has no stall and no backpressure path.
interface dcpu_intctl_if;
    logic [15:0] i_addr;
    logic [15:0] i_dat;
    logic        i_rw;
    logic [15:0] o_dat;

    modport master (
        output i_addr,
        output i_dat,
        output i_rw,
        input  o_dat
    );

    modport slave (
        input  i_addr,
        input  i_dat,
        input  i_rw,
        output o_dat
    );
endinterface

// File: rtl/dcpu_intctl.sv
// Interrupt controller: synchronised sources latch into PENDING, gated by MASK onto o_int.
// Latency: reads are combinational; an i_irq rise before edge E1 raises o_int after E3.
// Backpressure: none, every bus access is accepted in its own cycle.
module dcpu_intctl #(
    parameter logic [15:0] BASE_ADDR = 16'hFF00,
    parameter int          NSRC      = 8
) (
    input  logic            i_clk,
    input  logic            i_reset_n,
    input  logic [NSRC-1:0] i_irq,
    dcpu_intctl_if.slave    bus,
    output logic            o_int
);

    localparam int PW = 16 - NSRC;

    localparam logic [1:0] REG_PENDING = 2'd0;
    localparam logic [1:0] REG_MASK    = 2'd1;
    localparam logic [1:0] REG_EDGE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    logic [NSRC-1:0] s1;
    logic [NSRC-1:0] s2;
    logic [NSRC-1:0] s3;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] mask;
    logic [NSRC-1:0] edge_mode;

    logic            sel;
    logic            wr_vld;
    logic [1:0]      reg_idx;
    logic [NSRC-1:0] wr_dat;
    logic [NSRC-1:0] hw_set;
    logic [NSRC-1:0] sw_set;
    logic [NSRC-1:0] w1c_clr;
    logic [NSRC-1:0] pending_nxt;
    logic [NSRC-1:0] active;
    logic [3:0]      first_idx;
    logic [15:0]     status;
    logic [15:0]     rd_dat;

    // Address bit 0 and the upper write-data bits never reach any register.
    logic unused_bits;
    assign unused_bits = &{1'b0, bus.i_addr[0], bus.i_dat, BASE_ADDR[2:0]};

    assign sel     = (bus.i_addr[15:3] == BASE_ADDR[15:3]);
    assign reg_idx = bus.i_addr[2:1];
    assign wr_vld  = sel && !bus.i_rw;
    assign wr_dat  = bus.i_dat[NSRC-1:0];

    // Edge sources fire only on s2 rising; level sources re-assert every cycle s2 is high.
    assign hw_set  = s2 & (~edge_mode | ~s3);
    assign sw_set  = (wr_vld && reg_idx == REG_STATUS)  ? wr_dat : '0;
    assign w1c_clr = (wr_vld && reg_idx == REG_PENDING) ? wr_dat : '0;

    // Sets are OR-ed after the clear so a coincident set always wins.
    assign pending_nxt = (pending & ~w1c_clr) | hw_set | sw_set;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= i_irq;
            s2 <= s1;
            s3 <= s2;
        end
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            pending   <= '0;
            mask      <= '0;
            edge_mode <= '0;
        end else begin
            pending <= pending_nxt;
            if (wr_vld && reg_idx == REG_MASK) begin
                mask <= wr_dat;
            end
            if (wr_vld && reg_idx == REG_EDGE) begin
                edge_mode <= wr_dat;
            end
        end
    end

    assign active = pending & mask;
    assign o_int  = |active;

    // Walk from the top down so the lowest-numbered active source is the one left standing.
    always_comb begin
        first_idx = 4'd0;
        for (int k = NSRC - 1; k >= 0; k--) begin
            if (active[k]) begin
                first_idx = 4'(k);
            end
        end
    end

    assign status = {o_int, 11'd0, first_idx};

    always_comb begin
        rd_dat = 16'h0000;
        if (sel && bus.i_rw) begin
            case (reg_idx)
                REG_PENDING: rd_dat = {{PW{1'b0}}, pending};
                REG_MASK:    rd_dat = {{PW{1'b0}}, mask};
                REG_EDGE:    rd_dat = {{PW{1'b0}}, edge_mode};
                default:     rd_dat = status;
            endcase
        end
    end

    assign bus.o_dat = rd_dat;

endmodule

// File: tb/tb_dcpu_intctl.sv
// Self-checking bench for dcpu_intctl: directed register scenarios plus randomized traffic
// checked against a register-level reference model.
module tb_dcpu_intctl;

    localparam int          NSRC  = 8;
    localparam logic [15:0] NMASK = 16'h00FF;

    logic            i_clk = 1'b0;
    logic            i_reset_n;
    logic [NSRC-1:0] i_irq;
    logic            o_int;

    int total = 0;
    int bad   = 0;

    dcpu_intctl_if bus ();

    dcpu_intctl #(.BASE_ADDR(16'hFF00), .NSRC(NSRC)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_irq     (i_irq),
        .bus       (bus),
        .o_int     (o_int)
    );

    always #5 i_clk = ~i_clk;

    // Reference model: architectural registers plus the irq level seen at each past clock edge.
    logic [15:0] m_pend, m_mask, m_edge;
    logic [15:0] seen [3];

    task automatic model_clear();
        m_pend = 16'h0; m_mask = 16'h0; m_edge = 16'h0;
        for (int i = 0; i < 3; i++) seen[i] = 16'h0;
    endtask

    task automatic model_step();
        logic [15:0] hw, clr, sw;
        logic        wr;
        if (!i_reset_n) begin
            model_clear();
        end else begin
            // seen[1] is the synchronised level now, seen[2] the one a cycle earlier.
            hw  = seen[1] & (~m_edge | ~seen[2]) & NMASK;
            wr  = (bus.i_addr[15:3] == 13'h1FE0) && !bus.i_rw;
            clr = (wr && bus.i_addr[2:1] == 2'd0) ? bus.i_dat : 16'h0;
            sw  = (wr && bus.i_addr[2:1] == 2'd3) ? bus.i_dat : 16'h0;
            m_pend = ((m_pend & ~clr) | hw | sw) & NMASK;
            if (wr && bus.i_addr[2:1] == 2'd1) m_mask = bus.i_dat & NMASK;
            if (wr && bus.i_addr[2:1] == 2'd2) m_edge = bus.i_dat & NMASK;
            seen[2] = seen[1];
            seen[1] = seen[0];
            seen[0] = {8'h00, i_irq};
        end
    endtask

    function automatic logic m_int();
        return (m_pend & m_mask) != 16'h0;
    endfunction

    function automatic logic [15:0] m_read(input logic [15:0] a, input logic rw);
        logic [15:0] act;
        int          first;
        if (a[15:3] != 13'h1FE0 || !rw) return 16'h0;
        case (a[2:1])
            2'd0: return m_pend;
            2'd1: return m_mask;
            2'd2: return m_edge;
            default: begin
                act   = m_pend & m_mask;
                first = 0;
                for (int k = 15; k >= 0; k--) if (act[k]) first = k;
                return {act != 16'h0, 11'd0, 4'(first)};
            end
        endcase
    endfunction

    task automatic tick();
        @(posedge i_clk);
        model_step();
        #1;
    endtask

    task automatic bus_idle();
        bus.i_addr = 16'h0000;
        bus.i_dat  = 16'h0000;
        bus.i_rw   = 1'b1;
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [15:0] d);
        bus.i_addr = a;
        bus.i_dat  = d;
        bus.i_rw   = 1'b0;
        tick();
        bus_idle();
    endtask

    task automatic bus_read(input logic [15:0] a, output logic [15:0] d);
        bus.i_addr = a;
        bus.i_rw   = 1'b1;
        #1;
        d = bus.o_dat;
        bus_idle();
    endtask

    task automatic test_reset();
        logic [15:0] d;
        logic [15:0] addrs [5];
        addrs = '{16'hFF00, 16'hFF02, 16'hFF04, 16'hFF06, 16'hFF08};
        for (int i = 0; i < 5; i++) begin
            bus_read(addrs[i], d);
            total++;
            if (d !== 16'h0000) begin
                bad++;
                $display("FAIL reset_read addr=%h got=%h want=0000", addrs[i], d);
            end
        end
        total++;
        if (o_int !== 1'b0) begin
            bad++;
            $display("FAIL reset_int got=%b want=0", o_int);
        end
    endtask

    task automatic test_edge_irq();
        logic [15:0] d;
        bus_write(16'hFF02, 16'h0081);
        bus_write(16'hFF04, 16'h0001);
        i_irq = 8'h01;
        tick();
        i_irq = 8'h00;
        tick();
        total++;
        if (o_int !== 1'b0) begin
            bad++;
            $display("FAIL edge_int_early got=%b want=0", o_int);
        end
        tick();
        total++;
        if (o_int !== 1'b1) begin
            bad++;
            $display("FAIL edge_int_e3 got=%b want=1", o_int);
        end
        bus_read(16'hFF06, d);
        total++;
        if (d !== 16'h8000) begin
            bad++;
            $display("FAIL edge_status got=%h want=8000", d);
        end
        bus_read(16'hFF00, d);
        total++;
        if (d !== 16'h0001) begin
            bad++;
            $display("FAIL edge_pending got=%h want=0001", d);
        end
        bus_write(16'hFF00, 16'h0001);
        total++;
        if (o_int !== 1'b0) begin
            bad++;
            $display("FAIL edge_w1c_int got=%b want=0", o_int);
        end
    endtask

    task automatic test_level_w1c();
        logic [15:0] d;
        i_irq = 8'h80;
        repeat (3) tick();
        bus_write(16'hFF00, 16'h0080);
        tick();
        bus_read(16'hFF00, d);
        total++;
        if (d !== 16'h0080) begin
            bad++;
            $display("FAIL level_resticky got=%h want=0080", d);
        end
        i_irq = 8'h00;
        repeat (3) tick();
        bus_write(16'hFF00, 16'h0080);
        bus_read(16'hFF00, d);
        total++;
        if (d !== 16'h0000 || o_int !== 1'b0) begin
            bad++;
            $display("FAIL level_cleared pend=%h int=%b want pend=0000 int=0", d, o_int);
        end
    endtask

    task automatic test_swset_mask();
        logic [15:0] d;
        bus_write(16'hFF00, 16'hFFFF);
        bus_write(16'hFF02, 16'h0004);
        bus_write(16'hFF06, 16'h0006);
        bus_read(16'hFF06, d);
        total++;
        if (o_int !== 1'b1 || d !== 16'h8002) begin
            bad++;
            $display("FAIL swset_status int=%b status=%h want int=1 status=8002", o_int, d);
        end
        bus_write(16'hFF02, 16'h0000);
        bus_read(16'hFF00, d);
        total++;
        if (o_int !== 1'b0 || d !== 16'h0006) begin
            bad++;
            $display("FAIL mask_off int=%b pend=%h want int=0 pend=0006", o_int, d);
        end
        bus_read(16'hFF03, d);
        total++;
        if (d !== 16'h0000) begin
            bad++;
            $display("FAIL mask_odd_addr got=%h want=0000", d);
        end
    endtask

    task automatic test_set_wins();
        logic [15:0] d;
        bus_write(16'hFF00, 16'hFFFF);
        bus_write(16'hFF04, 16'h0002);
        bus_write(16'hFF02, 16'h0002);
        i_irq = 8'h02;
        tick();
        tick();
        // The W1C below lands on the very edge at which the source-1 edge is detected.
        bus_write(16'hFF00, 16'h0002);
        bus_read(16'hFF00, d);
        total++;
        if (d !== 16'h0002 || o_int !== 1'b1) begin
            bad++;
            $display("FAIL set_wins pend=%h int=%b want pend=0002 int=1", d, o_int);
        end
    endtask

    task automatic test_async_reset();
        logic [15:0] d;
        #1;
        i_reset_n = 1'b0;
        i_irq     = 8'h00;
        model_clear();
        #1;
        total++;
        if (o_int !== 1'b0) begin
            bad++;
            $display("FAIL areset_int got=%b want=0", o_int);
        end
        for (int r = 0; r < 4; r++) begin
            bus_read(16'hFF00 + 16'(2 * r), d);
            total++;
            if (d !== 16'h0000) begin
                bad++;
                $display("FAIL areset_reg idx=%0d got=%h want=0000", r, d);
            end
        end
        tick();
        i_reset_n = 1'b1;
        tick();
    endtask

    task automatic test_random();
        logic [15:0] a, d, want;
        logic [15:0] targets [6];
        targets = '{16'hFF00, 16'hFF02, 16'hFF04, 16'hFF06, 16'hFF09, 16'h1234};
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 3) == 0) i_irq = i_irq ^ 8'(1 << $urandom_range(0, NSRC - 1));
            a = targets[$urandom_range(0, 5)] | 16'($urandom_range(0, 1));
            case ($urandom_range(0, 2))
                0: begin
                    bus.i_addr = a;
                    bus.i_dat  = 16'($urandom);
                    bus.i_rw   = 1'b0;
                    #1;
                    total++;
                    if (bus.o_dat !== 16'h0000) begin
                        bad++;
                        $display("FAIL rnd_wr_odat n=%0d got=%h want=0000", n, bus.o_dat);
                    end
                    tick();
                    bus_idle();
                end
                1: begin
                    want = m_read(a, 1'b1);
                    bus_read(a, d);
                    total++;
                    if (d !== want) begin
                        bad++;
                        $display("FAIL rnd_read n=%0d addr=%h got=%h want=%h", n, a, d, want);
                    end
                    tick();
                end
                default: tick();
            endcase
            total++;
            if (o_int !== m_int()) begin
                bad++;
                $display("FAIL rnd_int n=%0d got=%b want=%b", n, o_int, m_int());
            end
        end
    endtask

    initial begin
        i_reset_n = 1'b0;
        i_irq     = '0;
        bus_idle();
        model_clear();
        repeat (3) tick();
        i_reset_n = 1'b1;
        tick();
        test_reset();
        test_edge_irq();
        test_level_w1c();
        test_swset_mask();
        test_set_wins();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
